mem_req_arbiter: RTL
====================

# mem_req_arbiter

Request arbiter directly upstream of the asynchronous-SRAM/BRAM memory controller. Merges two independent requesters, port A (CPU/APU side) and port B (PPU side), into the controller's single `read_a`/`read_b`/`write` strobe interface. Issues exactly one controller transaction at a time, tracks the controller's `busy` window, and returns read data plus a one-cycle `done` to the owning requester.

## Interface
Parameters:
- `AW`, 22: address width, matching the controller's 22-bit byte address.
- `DW`, 8: data width.

Ports:
- `clk`  in  1  system clock, same clock as the memory controller.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `a_req`  in  1  port A request pulse; sampled on a rising edge.
- `a_we`  in  1  port A write (1) or read (0); sampled with `a_req`.
- `a_addr`  in  AW  port A address; sampled with `a_req`.
- `a_din`  in  DW  port A write data; sampled with `a_req`.
- `a_done`  out  1  one-cycle pulse: the port A transaction is complete.
- `a_dout`  out  DW  port A read data; valid from `a_done` and held until the next A read completes.
- `b_req`, `b_we`, `b_addr`, `b_din`, `b_done`, `b_dout`: same as the A-side ports, for port B.
- `mc_read_a`  out  1  controller read strobe, attributed to port A.
- `mc_read_b`  out  1  controller read strobe, attributed to port B.
- `mc_write`  out  1  controller write strobe.
- `mc_addr`  out  AW  controller address.
- `mc_din`  out  DW  controller write data.
- `mc_busy`  in  1  controller busy flag.
- `mc_dout_a`  in  DW  controller latched read data for port A.
- `mc_dout_b`  in  DW  controller latched read data for port B.

## Operation
- Each port has a pending latch. `x_req` captures `x_we`, `x_addr` and `x_din` and sets `x_pend`. `x_pend` clears in the cycle `x_done` pulses.
- A `x_req` arriving in the same cycle as `x_done` for the same port is accepted and sets `x_pend` again.
- A `x_req` arriving while `x_pend` is already set is ignored; this is a protocol violation and is flagged only in simulation.
- State machine:
  - IDLE: if any port is pending and `mc_busy` is 0, grant one port, load `mc_addr`/`mc_din`, and go to ISSUE.
  - ISSUE: drive exactly one strobe for exactly one cycle. The strobe is `mc_write` if the latched `we` is 1; otherwise `mc_read_a` for port A or `mc_read_b` for port B. Go to WAITB.
  - WAITB: wait for `mc_busy` = 1, then go to WAITD.
  - WAITD: wait for `mc_busy` = 0, then go to DONE.
  - DONE: pulse the granted port's `x_done`. On a read, copy `mc_dout_a` or `mc_dout_b` into `x_dout`. Go to IDLE.
- All strobes are 0 outside ISSUE, so the controller never re-triggers when `busy` falls.
- `mc_addr` and `mc_din` stay stable from ISSUE through DONE.
- If both ports are pending in IDLE, arbitration follows Configuration.
- Reset values: all strobes 0, `mc_addr` 0, `mc_din` 0, `a_done`/`b_done` 0, `a_dout`/`b_dout` 0, pending latches cleared, state IDLE.
- Reset asserted mid-transaction abandons the transaction. No `done` is issued for it, and the controller finishes its window on its own.

## Timing
- All outputs are registered.
- Controller busy window: `busy` rises the cycle after the strobe and stays high for 3 cycles.
- Uncontended read or write: `x_req` in cycle 0 → pending in cycle 1 (IDLE grants) → strobe in cycle 2 → `busy` high in cycles 3–5 → `busy` low seen in cycle 6 → `x_done` in cycle 7.
  - Latency is 7 cycles from request to done.
- Back-to-back throughput: one transaction per 6 cycles. IDLE may grant in the same cycle that DONE exits, via a DONE→ISSUE bypass when a port is pending.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. A 1-bit last-grant pointer selects the other port when both are pending. The pointer resets to "last = B", so A wins the first tie.
- `MEM_ARB_RR_EN` undefined: fixed priority, with port B (PPU) always winning ties. Port A can be delayed by at most one B transaction per B request.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, WAITB, WAITD, DONE);
  - `AW`/`DW` defaults;
  - the port-index constants `PORT_A` = 0 and `PORT_B` = 1.
- Sub-module `mem_arb_port_latch`, instantiated twice: the request capture, pending flag, and `dout` holding register for one port.
- The top level holds the FSM, the arbiter, and the controller-facing registers.

## Test plan
- Port A read at 0x000123, controller model returns 0x5A → `mc_read_a` high for 1 cycle in cycle 2; `a_done` in cycle 7; `a_dout` = 0x5A; `b_done` stays 0.
- Port B write, address 0x200010, data 0xC3 → `mc_write` high for 1 cycle; `mc_addr` = 0x200010 and `mc_din` = 0xC3 held through DONE; `b_done` in cycle 7.
- A read and B read requested in the same cycle, with `MEM_ARB_RR_EN` → A served first, then B; `b_done` exactly 6 cycles after `a_done`. Without the macro → B first.
- `mc_busy` held high externally when A requests → no strobe until `busy` falls; then normal sequence.
- `a_req` re-issued in the same cycle as `a_done` → second transaction accepted; strobe follows with no lost request.
- `rst_n` pulsed low during WAITD → all outputs return to reset values immediately; no `done` for the aborted transaction; a new request after release completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for mem_req_arbiter (FSM states, default widths, port indices).
package mem_arb_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAITB, WAITD, DONE} state_t;
    localparam int DEF_AW = 22;
    localparam int DEF_DW = 8;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: requester ports A/B and memory-controller strobe interface of mem_req_arbiter.
//   a_*/b_* : req/we/addr/din in, done/dout out (per requester)
//   mc_*    : read_a/read_b/write/addr/din out, busy/dout_a/dout_b in (controller side)
//   master  : the arbiter's view; slave: the requesters' and controller's view
interface mem_req_arbiter_if #(
    parameter int AW = mem_arb_pkg::DEF_AW,
    parameter int DW = mem_arb_pkg::DEF_DW
);
    logic          a_req, a_we, a_done;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din, a_dout;
    logic          b_req, b_we, b_done;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_din, b_dout;
    logic          mc_read_a, mc_read_b, mc_write, mc_busy;
    logic [AW-1:0] mc_addr;
    logic [DW-1:0] mc_din, mc_dout_a, mc_dout_b;
    modport master (
        input  a_req, a_we, a_addr, a_din, b_req, b_we, b_addr, b_din,
        input  mc_busy, mc_dout_a, mc_dout_b,
        output a_done, a_dout, b_done, b_dout,
        output mc_read_a, mc_read_b, mc_write, mc_addr, mc_din
    );
    modport slave (
        output a_req, a_we, a_addr, a_din, b_req, b_we, b_addr, b_din,
        output mc_busy, mc_dout_a, mc_dout_b,
        input  a_done, a_dout, b_done, b_dout,
        input  mc_read_a, mc_read_b, mc_write, mc_addr, mc_din
    );
endinterface

// File: rtl/mem_arb_port_latch.sv
// mem_arb_port_latch: request capture, pending flag and read-data holding register for one requester.
//   req/we/addr/din        : request pulse and its attributes
//   fin                    : this port's granted transaction completes this cycle
//   mc_dout                : controller read data for this port
//   pend/we_q/addr_q/din_q : pending flag and captured request
//   done/dout              : completion pulse and held read data
module mem_arb_port_latch
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    input  logic          fin,
    input  logic [DW-1:0] mc_dout,
    output logic          pend,
    output logic          we_q,
    output logic [AW-1:0] addr_q,
    output logic [DW-1:0] din_q,
    output logic          done,
    output logic [DW-1:0] dout
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            done   <= 1'b0;
            dout   <= '0;
        end else begin
            done <= fin;
            // fin only happens while pending, so a request in that cycle is dropped
            pend <= fin ? 1'b0 : (pend | req);
            if (req && !pend) begin
                we_q   <= we;
                addr_q <= addr;
                din_q  <= din;
            end
            if (fin && !we_q)
                dout <= mc_dout;
        end
    end
    assert property (@(posedge clk) disable iff (!rst_n) !(req && pend))
        else $warning("mem_arb_port_latch: request while pending ignored");
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: merges requesters A and B onto the single-transaction memory-controller strobe interface.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_req_arbiter_if.master (requester ports A/B and controller signals)
//   MEM_ARB_RR_EN defined: round-robin on ties (A wins the first); undefined: B always wins ties
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input logic               clk,
    input logic               rst_n,
    mem_req_arbiter_if.master bus
);
    logic          pend_a, pend_b, we_a, we_b, pick, gnt, fin, load, sel_we;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] din_a, din_b;
    state_t        state, state_nxt;
`ifdef MEM_ARB_RR_EN
    logic last;
    // on a tie, serve whichever port did not win the previous grant
    assign pick = (pend_a && pend_b) ? ~last : (pend_b ? PORT_B : PORT_A);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= PORT_B;
        else if (load)
            last <= pick;
    end
`else
    assign pick = pend_b ? PORT_B : PORT_A;
`endif
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = ((pend_a || pend_b) && !bus.mc_busy) ? ISSUE : IDLE;
            ISSUE:   state_nxt = WAITB;
            WAITB:   state_nxt = bus.mc_busy ? WAITD : WAITB;
            WAITD:   state_nxt = bus.mc_busy ? WAITD : DONE;
            DONE:    state_nxt = ((pend_a || pend_b) && !bus.mc_busy) ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    assign load   = state_nxt == ISSUE;
    assign fin    = state == WAITD && !bus.mc_busy;
    assign sel_we = pick ? we_b : we_a;
    // strobes are registered on entry to ISSUE so they are high for exactly that one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            gnt           <= PORT_A;
            bus.mc_read_a <= 1'b0;
            bus.mc_read_b <= 1'b0;
            bus.mc_write  <= 1'b0;
            bus.mc_addr   <= '0;
            bus.mc_din    <= '0;
        end else begin
            state         <= state_nxt;
            bus.mc_read_a <= load && !sel_we && pick == PORT_A;
            bus.mc_read_b <= load && !sel_we && pick == PORT_B;
            bus.mc_write  <= load && sel_we;
            if (load) begin
                gnt         <= pick;
                bus.mc_addr <= pick ? addr_b : addr_a;
                bus.mc_din  <= pick ? din_b : din_a;
            end
        end
    end
    mem_arb_port_latch #(.AW(AW), .DW(DW)) u_lat_a (
        .clk(clk), .rst_n(rst_n),
        .req(bus.a_req), .we(bus.a_we), .addr(bus.a_addr), .din(bus.a_din),
        .fin(fin && gnt == PORT_A), .mc_dout(bus.mc_dout_a),
        .pend(pend_a), .we_q(we_a), .addr_q(addr_a), .din_q(din_a),
        .done(bus.a_done), .dout(bus.a_dout)
    );
    mem_arb_port_latch #(.AW(AW), .DW(DW)) u_lat_b (
        .clk(clk), .rst_n(rst_n),
        .req(bus.b_req), .we(bus.b_we), .addr(bus.b_addr), .din(bus.b_din),
        .fin(fin && gnt == PORT_B), .mc_dout(bus.mc_dout_b),
        .pend(pend_b), .we_q(we_b), .addr_q(addr_b), .din_q(din_b),
        .done(bus.b_done), .dout(bus.b_dout)
    );
endmodule
